// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin front end for a shared FP multiplier pipe with special-value bypass and per-requester result FIFOs
module fmul_arbiter #(
  parameter int LAT = 3,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             pipe_valid,
  output logic [31:0]      pipe_a,
  output logic [31:0]      pipe_b,
  input  logic [31:0]      pipe_res,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [1:0] elig, gnt, pop, push, ne;
  logic [CW-1:0] cred [2];
  logic last, gid, spec, sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0] ga, gb, sval, res;
  logic [TAG_W-1:0] gtag;
  logic [LAT:0] sh_v, sh_id, sh_sp;
  logic [TAG_W-1:0] sh_tag [LAT+1];
  logic [31:0] sh_val [LAT+1];
  logic [31:0] fd [2][DEPTH];
  logic [TAG_W-1:0] ft [2][DEPTH];
  logic [AW:0] wp [2], rp [2];
  always_comb begin
    elig[0] = req0_valid && cred[0] < CW'(DEPTH);
    elig[1] = req1_valid && cred[1] < CW'(DEPTH);
    // last == 1 means requester 1 won most recently, so 0 has priority
    gnt[0] = rst_n && elig[0] && (!elig[1] || last);
    gnt[1] = rst_n && elig[1] && (!elig[0] || !last);
    gid = gnt[1];
    ga = gid ? req1_a : req0_a;
    gb = gid ? req1_b : req0_b;
    gtag = gid ? req1_tag : req0_tag;
    a_nan = &ga[30:23] && |ga[22:0];
    b_nan = &gb[30:23] && |gb[22:0];
    a_inf = &ga[30:23] && !(|ga[22:0]);
    b_inf = &gb[30:23] && !(|gb[22:0]);
    a_zero = !(|ga[30:23]);
    b_zero = !(|gb[30:23]);
    sgn = ga[31] ^ gb[31];
    spec = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    sval = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? 32'h7FC00000 :
           (a_inf || b_inf) ? {sgn, 8'hFF, 23'h0} : {sgn, 31'h0};
    push[0] = sh_v[LAT] && !sh_id[LAT];
    push[1] = sh_v[LAT] && sh_id[LAT];
    res = sh_sp[LAT] ? sh_val[LAT] : pipe_res;
    ne[0] = wp[0] != rp[0];
    ne[1] = wp[1] != rp[1];
    pop = {rsp1_ready, rsp0_ready} & ne;
  end
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = ne[0];
  assign rsp1_valid = ne[1];
  assign rsp0_data = ne[0] ? fd[0][rp[0][AW-1:0]] : '0;
  assign rsp1_data = ne[1] ? fd[1][rp[1][AW-1:0]] : '0;
  assign rsp0_tag = ne[0] ? ft[0][rp[0][AW-1:0]] : '0;
  assign rsp1_tag = ne[1] ? ft[1][rp[1][AW-1:0]] : '0;
  assign busy = (|cred[0]) || (|cred[1]);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
      sh_v <= '0;
      pipe_valid <= 1'b0;
      pipe_a <= '0;
      pipe_b <= '0;
    end else begin
      if (|gnt) last <= gid;
      sh_v <= {sh_v[LAT-1:0], |gnt};
      pipe_valid <= |gnt && !spec;
      if (|gnt && !spec) begin
        pipe_a <= ga;
        pipe_b <= gb;
      end
    end
  end
  always_ff @(posedge clk) begin
    sh_id <= {sh_id[LAT-1:0], gid};
    sh_sp <= {sh_sp[LAT-1:0], spec};
    sh_tag[0] <= gtag;
    sh_val[0] <= sval;
    for (int i = 1; i <= LAT; i++) begin
      sh_tag[i] <= sh_tag[i-1];
      sh_val[i] <= sh_val[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cred[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          fd[i][wp[i][AW-1:0]] <= res;
          ft[i][wp[i][AW-1:0]] <= sh_tag[LAT];
          wp[i] <= wp[i] + 1'b1;
        end
        if (pop[i]) rp[i] <= rp[i] + 1'b1;
        cred[i] <= cred[i] + CW'(gnt[i]) - CW'(pop[i]);
      end
    end
  end
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: scoreboard bench with a stand-in multiplier pipe of LAT cycles
module tb_fmul_arbiter;
  localparam int LAT = 3, DEPTH = 4, TAG_W = 4;
  typedef struct packed { logic [31:0] a, b; logic [TAG_W-1:0] tag; } op_t;
  logic clk = 0, rst_n = 0;
  logic rv0 = 0, rv1 = 0, rr0 = 1, rr1 = 1;
  logic [31:0] ra0 = 0, rb0 = 0, ra1 = 0, rb1 = 0, pipe_res = 0;
  logic [TAG_W-1:0] rt0 = 0, rt1 = 0;
  logic req0_ready, req1_ready, pipe_valid, rsp0_valid, rsp1_valid, busy;
  logic [31:0] pipe_a, pipe_b, rsp0_data, rsp1_data;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  op_t sq0[$], sq1[$];
  logic [TAG_W+31:0] exp0[$], exp1[$];
  int gseq[$];
  int checks = 0, errors = 0, cyc = 0, g0 = 0, g1 = 0, pv_cnt = 0;
  int b0, b1, gc, bad;
  logic x0 = 0, x1 = 0;
  logic dv [LAT+1];
  logic [31:0] dr [LAT+1];

  fmul_arbiter #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv0), .req0_ready(req0_ready), .req0_a(ra0), .req0_b(rb0), .req0_tag(rt0),
    .req1_valid(rv1), .req1_ready(req1_ready), .req1_a(ra1), .req1_b(rb1), .req1_tag(rt1),
    .pipe_valid(pipe_valid), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_res(pipe_res),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr0), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr1), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
    .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
    return a + b - 32'h3F800000;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic na, nb, ia, ib, za, zb, s;
    na = a[30:23] == 8'hFF && a[22:0] != 0;
    nb = b[30:23] == 8'hFF && b[22:0] != 0;
    ia = a[30:23] == 8'hFF && a[22:0] == 0;
    ib = b[30:23] == 8'hFF && b[22:0] == 0;
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    s = a[31] ^ b[31];
    if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    return fake_mul(a, b);
  endfunction

  always @(posedge clk) begin
    #1;
    if (x0 && sq0.size() > 0) void'(sq0.pop_front());
    if (x1 && sq1.size() > 0) void'(sq1.pop_front());
    rv0 = sq0.size() > 0;
    rv1 = sq1.size() > 0;
    if (rv0) {ra0, rb0, rt0} = sq0[0];
    if (rv1) {ra1, rb1, rt1} = sq1[0];
  end

  always @(negedge clk) begin
    x0 = rst_n && rv0 && req0_ready;
    x1 = rst_n && rv1 && req1_ready;
    if (x0) begin g0++; gseq.push_back(0); exp0.push_back({rt0, model(ra0, rb0)}); end
    if (x1) begin g1++; gseq.push_back(1); exp1.push_back({rt1, model(ra1, rb1)}); end
    if (rst_n && pipe_valid) pv_cnt++;
    if (rst_n && rsp0_valid && rr0) begin
      if (exp0.size() == 0) check("rsp0_spurious", exp0.size(), 1);
      else check("rsp0", {rsp0_tag, rsp0_data}, exp0.pop_front());
    end
    if (rst_n && rsp1_valid && rr1) begin
      if (exp1.size() == 0) check("rsp1_spurious", exp1.size(), 1);
      else check("rsp1", {rsp1_tag, rsp1_data}, exp1.pop_front());
    end
    for (int i = LAT; i > 0; i--) begin
      dv[i] = dv[i-1];
      dr[i] = dr[i-1];
    end
    dv[0] = pipe_valid === 1'b1;
    dr[0] = fake_mul(pipe_a, pipe_b);
    pipe_res = dv[LAT] ? dr[LAT] : 32'hDEADBEEF;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    sq0.delete(); sq1.delete(); exp0.delete(); exp1.delete();
    tick(1);
    rst_n = 1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((sq0.size() + sq1.size() + exp0.size() + exp1.size() != 0 || busy) && k < 500) begin
      tick(1);
      k++;
    end
    check(tag, k < 500, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i <= LAT; i++) begin dv[i] = 0; dr[i] = 0; end
    sq0.push_back({32'h3F800000, 32'h40000000, 4'd5});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_pipe_valid", pipe_valid, 0);
    check("rst_pipe_a", pipe_a, 0);
    check("rst_pipe_b", pipe_b, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp1_tag", rsp1_tag, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst_n = 1;
    for (int i = 0; i < 20 && !(rv0 && req0_ready); i++) @(negedge clk);
    gc = cyc;
    for (int i = 0; i < 20 && !rsp0_valid; i++) @(negedge clk);
    check("single_latency", cyc - gc, 5);
    check("single_data", rsp0_data, 32'h40000000);
    check("single_tag", rsp0_tag, 5);
    wait_idle("single_drain");
    check("single_pv", pv_cnt, 1);

    b0 = pv_cnt;
    sq1.push_back({32'h7F800000, 32'h00000000, 4'd1});
    sq1.push_back({32'hFF800000, 32'h40000000, 4'd2});
    sq1.push_back({32'h80000000, 32'h3F800000, 4'd3});
    wait_idle("spec_drain");
    check("spec_no_pipe", pv_cnt - b0, 0);

    b0 = pv_cnt;
    sq0.push_back({32'h40400000, 32'h40000000, 4'd1});
    sq0.push_back({32'h00000000, 32'hC0000000, 4'd2});
    sq0.push_back({32'h3FC00000, 32'h40800000, 4'd3});
    wait_idle("mixed_drain");
    check("mixed_pv", pv_cnt - b0, 2);

    do_reset();
    gseq.delete();
    for (int i = 0; i < 6; i++) begin
      sq0.push_back({$urandom(), $urandom(), 4'(i)});
      sq1.push_back({$urandom(), $urandom(), 4'(i + 8)});
    end
    wait_idle("rr_drain");
    check("rr_count", gseq.size(), 12);
    for (int i = 0; i < gseq.size(); i++) check("rr_order", gseq[i], i % 2);

    b0 = g0; b1 = g1;
    rr0 = 0;
    for (int i = 0; i < 8; i++) sq0.push_back({32'h3F800000 + (i << 23), 32'h40000000, 4'(i)});
    for (int i = 0; i < 6; i++) sq1.push_back({32'h40400000, 32'h3F800000 + (i << 23), 4'(i)});
    tick(30);
    check("bp_grants0", g0 - b0, 4);
    check("bp_stalled", req0_ready, 0);
    check("bp_grants1", g1 - b1, 6);
    check("bp_busy", busy, 1);
    rr0 = 1;
    tick(1);
    rr0 = 0;
    tick(20);
    check("bp_one_more", g0 - b0, 5);
    rr0 = 1;
    wait_idle("bp_drain");

    b0 = g0;
    for (int i = 0; i < 3; i++) sq0.push_back({32'h40000000, 32'h40000000, 4'(i)});
    tick(4);
    check("midrst_issued", g0 - b0, 3);
    do_reset();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) bad++;
    end
    check("midrst_quiet", bad, 0);
    tick(1);
    rr0 = 0;
    b0 = g0;
    for (int i = 0; i < 5; i++) sq0.push_back({32'h3F800000, 32'h40400000, 4'(i)});
    tick(15);
    check("midrst_credits", g0 - b0, 4);
    rr0 = 1;
    wait_idle("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
